// File: rtl/tlc_phase_rr_pkg.sv
// tlc_phase_rr_pkg
// Shared definitions for the phase-based traffic light controller:
//   - colors      : 2-bit light encoding driven on each light pair
//   - tlc_state_t : controller state (all-red, green, yellow)
//   - default phase masks for the 5-sensor / 5-light intersection
//     (bit order 0 e_str, 1 w_str, 2 e_left, 3 w_left, 4 ns)
//   - ctr_w       : width of a counter that must hold 0..max_val
// No ports (package).
package tlc_phase_rr_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } colors;

  typedef enum logic [1:0] {
    TLC_ALLRED = 2'd0,
    TLC_GREEN  = 2'd1,
    TLC_YELLOW = 2'd2
  } tlc_state_t;

  // Slice p (5 bits each, phase 0 in the LSBs):
  //   p0 e_str+w_str, p1 e_str+e_left, p2 w_str+w_left, p3 both lefts, p4 ns
  localparam logic [24:0] DEF_PHASE_SENSORS = 25'b10000_01100_01010_00101_00011;
  localparam logic [24:0] DEF_PHASE_LIGHTS  = 25'b10000_01100_01010_00101_00011;

  // A counter whose largest value is 0 still needs one bit to exist.
  function automatic int ctr_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/tlc_phase_rr_pick.sv
// rr_phase_pick
// Combinational round-robin selector. Starting after the last served
// phase, scans last+1, last+2, ... modulo NUM_PHASES and returns the first
// phase with demand; the last phase itself is considered last of all.
// Ports:
//   demand [NUM_PHASES-1:0]       in  per-phase request
//   last   [$clog2(NUM_PHASES)]   in  most recently served phase
//   found                         out some phase has demand
//   pick   [$clog2(NUM_PHASES)]   out selected phase (== last when !found)
module rr_phase_pick
  import tlc_phase_rr_pkg::*;
#(
  parameter int NUM_PHASES = 5
) (
  input  logic [NUM_PHASES-1:0]         demand,
  input  logic [$clog2(NUM_PHASES)-1:0] last,
  output logic                          found,
  output logic [$clog2(NUM_PHASES)-1:0] pick
);

  localparam int PW = $clog2(NUM_PHASES);

  // cand[i] is the phase i steps after last; cand[NUM_PHASES] wraps to last.
  logic [PW-1:0] cand [1:NUM_PHASES];

  for (genvar i = 1; i <= NUM_PHASES; i++) begin : g_cand
    assign cand[i] = PW'((32'(last) + 32'(i)) % 32'(NUM_PHASES));
  end

  // Walk from the farthest candidate to the nearest so the nearest
  // requesting phase is the final assignment.
  always_comb begin
    found = 1'b0;
    pick  = last;
    for (int i = NUM_PHASES; i >= 1; i--) begin
      if (demand[cand[i]]) begin
        found = 1'b1;
        pick  = cand[i];
      end
    end
  end

endmodule

// File: rtl/tlc_phase_rr.sv
// tlc_phase_rr
// N-phase round-robin traffic light controller (Moore). Each phase has a
// sensor mask (who requests it) and a light mask (who goes green). Phases
// are served round-robin with green-max and vacancy timeouts, a fixed
// yellow time and a minimum all-red time, plus emergency preemption.
// Ports:
//   clk            in  clock
//   reset          in  synchronous active-high reset
//   sensors        in  [NUM_SENSORS] traffic sensors
//   preempt        in  emergency preemption request
//   preempt_phase  in  [$clog2(NUM_PHASES)] preemption target phase
//   lights         out [2*NUM_LIGHTS] color of light i at [2i+1:2i]
//   cur_phase      out [$clog2(NUM_PHASES)] phase last granted green
//   green_active   out high while in GREEN
module tlc_phase_rr
  import tlc_phase_rr_pkg::*;
#(
  parameter int NUM_PHASES  = 5,
  parameter int NUM_SENSORS = 5,
  parameter int NUM_LIGHTS  = 5,
  parameter logic [NUM_PHASES*NUM_SENSORS-1:0] PHASE_SENSORS = DEF_PHASE_SENSORS,
  parameter logic [NUM_PHASES*NUM_LIGHTS-1:0]  PHASE_LIGHTS  = DEF_PHASE_LIGHTS,
  parameter int GREEN_MAX   = 10,
  parameter int VACANT_TO   = 5,
  parameter int YELLOW_CYC  = 2,
  parameter int ALLRED_CYC  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SENSORS-1:0]        sensors,
  input  logic                          preempt,
  input  logic [$clog2(NUM_PHASES)-1:0] preempt_phase,
  output logic [2*NUM_LIGHTS-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] cur_phase,
  output logic                          green_active
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int GW = ctr_w(GREEN_MAX - 1);
  localparam int VW = ctr_w(VACANT_TO - 1);
  localparam int YW = ctr_w(YELLOW_CYC - 1);
  localparam int AW = ctr_w(ALLRED_CYC - 1);

  localparam logic [GW-1:0] G_LAST = GW'(GREEN_MAX - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VACANT_TO - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(YELLOW_CYC - 1);
  localparam logic [AW-1:0] A_LAST = AW'(ALLRED_CYC - 1);

  tlc_state_t      state_q, state_d;
  logic [PW-1:0]   cur_phase_q, cur_phase_d;
  logic [GW-1:0]   g_ctr_q, g_ctr_d;
  logic [VW-1:0]   v_ctr_q, v_ctr_d;
  logic [YW-1:0]   y_ctr_q, y_ctr_d;
  logic [AW-1:0]   ar_ctr_q, ar_ctr_d;

  logic [NUM_PHASES-1:0] demand, conflict;
  logic                  pre_ok;
  logic                  rr_found;
  logic [PW-1:0]         rr_pick;
  logic [NUM_LIGHTS-1:0] lit_mask;
  colors                 on_color;

  always_comb begin
    for (int p = 0; p < NUM_PHASES; p++) begin
      demand[p]   = |(sensors &  PHASE_SENSORS[p*NUM_SENSORS +: NUM_SENSORS]);
      conflict[p] = |(sensors & ~PHASE_SENSORS[p*NUM_SENSORS +: NUM_SENSORS]);
    end
  end

  // An out-of-range target phase makes the request meaningless; drop it.
  assign pre_ok = preempt && (32'(preempt_phase) < 32'(NUM_PHASES));

  rr_phase_pick #(.NUM_PHASES(NUM_PHASES)) u_pick (
    .demand (demand),
    .last   (cur_phase_q),
    .found  (rr_found),
    .pick   (rr_pick)
  );

  always_comb begin
    state_d     = state_q;
    cur_phase_d = cur_phase_q;
    g_ctr_d     = g_ctr_q;
    v_ctr_d     = v_ctr_q;
    y_ctr_d     = y_ctr_q;
    ar_ctr_d    = ar_ctr_q;
    unique case (state_q)
      TLC_ALLRED: begin
        if (ar_ctr_q == A_LAST) begin
          // Preemption and new grants are only honoured here, so yellow
          // and the minimum all-red are never cut short.
          if (pre_ok) begin
            state_d     = TLC_GREEN;
            cur_phase_d = preempt_phase;
            ar_ctr_d    = '0;
          end else if (rr_found) begin
            state_d     = TLC_GREEN;
            cur_phase_d = rr_pick;
            ar_ctr_d    = '0;
          end
        end else begin
          ar_ctr_d = ar_ctr_q + AW'(1);
        end
      end
      TLC_GREEN: begin
        g_ctr_d = (g_ctr_q == G_LAST) ? g_ctr_q : g_ctr_q + GW'(1);
        if (demand[cur_phase_q]) v_ctr_d = '0;
        else                     v_ctr_d = (v_ctr_q == V_LAST) ? v_ctr_q : v_ctr_q + VW'(1);
        // A preemption aimed at the running phase pins it green and
        // masks both timeouts.
        if ((pre_ok && preempt_phase != cur_phase_q) ||
            (!pre_ok && g_ctr_q == G_LAST && conflict[cur_phase_q]) ||
            (!pre_ok && v_ctr_q == V_LAST && !demand[cur_phase_q])) begin
          state_d = TLC_YELLOW;
          g_ctr_d = '0;
          v_ctr_d = '0;
          y_ctr_d = '0;
        end
      end
      TLC_YELLOW: begin
        if (y_ctr_q == Y_LAST) begin
          state_d  = TLC_ALLRED;
          y_ctr_d  = '0;
          ar_ctr_d = '0;
        end else begin
          y_ctr_d = y_ctr_q + YW'(1);
        end
      end
      default: begin
        state_d = TLC_ALLRED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TLC_ALLRED;
      cur_phase_q <= PW'(NUM_PHASES - 1);
      g_ctr_q     <= '0;
      v_ctr_q     <= '0;
      y_ctr_q     <= '0;
      ar_ctr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_phase_q <= cur_phase_d;
      g_ctr_q     <= g_ctr_d;
      v_ctr_q     <= v_ctr_d;
      y_ctr_q     <= y_ctr_d;
      ar_ctr_q    <= ar_ctr_d;
    end
  end

  // Light decode uses only registered state; lights outside the current
  // phase mask (including lights in no phase at all) stay red.
  always_comb begin
    lit_mask = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (cur_phase_q == PW'(p)) lit_mask = PHASE_LIGHTS[p*NUM_LIGHTS +: NUM_LIGHTS];
    end
    unique case (state_q)
      TLC_GREEN:  on_color = GREEN;
      TLC_YELLOW: on_color = YELLOW;
      default:    on_color = RED;
    endcase
    lights = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      lights[2*i +: 2] = lit_mask[i] ? on_color : RED;
    end
  end

  assign cur_phase    = cur_phase_q;
  assign green_active = (state_q == TLC_GREEN);

endmodule

// File: tb/tb_tlc_phase_rr.sv
// Directed-vector bench for tlc_phase_rr. The stimulus process drives the
// inputs and, for every clock edge, queues the hand-derived outputs that
// must follow that edge; a monitor pops one entry per falling edge and
// compares it with the DUT.
module tb_tlc_phase_rr;

  localparam logic [1:0] C_RED = 2'b00;
  localparam logic [1:0] C_YEL = 2'b01;
  localparam logic [1:0] C_GRN = 2'b10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sensors;
  logic       preempt;
  logic [2:0] preempt_phase;
  logic [9:0] lights;
  logic [2:0] cur_phase;
  logic       green_active;

  always #5 clk = ~clk;

  tlc_phase_rr dut (
    .clk           (clk),
    .reset         (reset),
    .sensors       (sensors),
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
    .lights        (lights),
    .cur_phase     (cur_phase),
    .green_active  (green_active)
  );

  typedef struct {
    logic [9:0] lights;
    logic [2:0] phase;
    logic       ga;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-written light masks of the default phases.
  function automatic logic [9:0] exp_lights(input logic [1:0] col, input int p);
    logic [4:0] m;
    logic [9:0] l;
    case (p)
      0:       m = 5'b00011;
      1:       m = 5'b00101;
      2:       m = 5'b01010;
      3:       m = 5'b01100;
      default: m = 5'b10000;
    endcase
    l = '0;
    for (int i = 0; i < 5; i++) l[2*i +: 2] = m[i] ? col : C_RED;
    return l;
  endfunction

  task automatic cyc(input int n, input logic [1:0] col, input int p, input string nm);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      e.lights = exp_lights(col, p);
      e.phase  = 3'(p);
      e.ga     = (col == C_GRN);
      e.name   = nm;
      exp_q.push_back(e);
      #1;
    end
  endtask

  task automatic green(input int p, input int n, input string nm);
    cyc(n, C_GRN, p, nm);
  endtask

  task automatic yellow(input int p, input int n, input string nm);
    cyc(n, C_YEL, p, nm);
  endtask

  task automatic allred(input int p, input int n, input string nm);
    cyc(n, C_RED, p, nm);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (lights !== e.lights || cur_phase !== e.phase || green_active !== e.ga) begin
          errors++;
          $display("FAIL %s @%0t: got lights=%b phase=%0d green_active=%b, want lights=%b phase=%0d green_active=%b",
                   e.name, $time, lights, cur_phase, green_active, e.lights, e.phase, e.ga);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; sensors = 5'b00000; preempt = 1'b0; preempt_phase = 3'd0;
    allred(4, 2, "reset");
    reset = 1'b0;
    allred(4, 20, "idle");

    sensors = 5'b00001;
    green(0, 1, "p0_first");

    // Continuous conflict: exactly GREEN_MAX green cycles per phase.
    sensors = 5'b10001;
    green(0, 9, "p0_gmax");
    yellow(0, 2, "p0_yel");
    allred(0, 1, "p0_ar");
    green(1, 10, "p1_gmax");
    yellow(1, 2, "p1_yel");
    allred(1, 1, "p1_ar");
    green(4, 1, "p4_enter");

    // Vacancy timeout.
    sensors = 5'b10000;
    green(4, 3, "p4_hold");
    sensors = 5'b00000;
    green(4, 4, "p4_vacant");
    yellow(4, 2, "p4_vac_yel");
    allred(4, 5, "ar_hold");

    // Short gap in demand must reset the vacancy count.
    sensors = 5'b10000;
    green(4, 1, "p4_again");
    green(4, 4, "p4_hold2");
    sensors = 5'b00000;
    green(4, 3, "ns_gap");
    sensors = 5'b10000;
    green(4, 8, "ns_back");
    sensors = 5'b00000;
    green(4, 4, "vac2");
    yellow(4, 2, "vac2_yel");
    allred(4, 1, "vac2_ar");

    // Preemption to phase 4 during phase 0 green cycle 3.
    sensors = 5'b11111;
    green(0, 1, "pre_p0");
    green(0, 2, "pre_p0_run");
    preempt = 1'b1; preempt_phase = 3'd4;
    yellow(0, 2, "pre_yel");
    allred(0, 1, "pre_ar");
    green(4, 15, "pre_hold");

    // Out-of-range target: request ignored, green-max applies again.
    preempt_phase = 3'd7;
    yellow(4, 2, "pre_bad_yel");
    allred(4, 1, "pre_bad_ar");
    green(0, 1, "rr0_enter");
    preempt = 1'b0;
    green(0, 9, "rr0");
    yellow(0, 2, "rr0_yel");
    allred(0, 1, "rr0_ar");
    for (int p = 1; p < 5; p++) begin
      green(p, 10, $sformatf("rr_g%0d", p));
      yellow(p, 2, $sformatf("rr_y%0d", p));
      allred(p, 1, $sformatf("rr_ar%0d", p));
    end
    green(0, 10, "rr_wrap0");
    yellow(0, 2, "rr_wrap0_yel");
    allred(0, 1, "rr_wrap0_ar");
    green(1, 10, "rr_wrap1");
    yellow(1, 2, "rr_wrap1_yel");
    allred(1, 1, "rr_wrap1_ar");
    green(2, 10, "rr_wrap2");
    yellow(2, 1, "p2_yel");

    // Reset in the middle of yellow.
    reset = 1'b1;
    allred(4, 1, "mid_reset");
    reset = 1'b0;
    green(0, 10, "post_reset");
    yellow(0, 1, "post_reset_yel");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
